alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter and sequencer that time-shares the single combinational `alu` instance between two requesters (port 0: execute stage, port 1: branch/compare unit). Accepts operand/op bundles over valid/ready, picks one per cycle by round-robin, registers the ALU result and overflow, and returns them over valid/ready to the requester that issued them. The block sits between the requesters and the `alu` and owns all of the `alu`'s inputs.

## Interface

Parameters:
- `DATA_LEN`, default 32: operand and result width, passed to `alu`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 2: request valid, bit i is port i.
- `req_ready`, out, 2: request accepted this cycle when `req_valid[i] & req_ready[i]`.
- `req_a0` / `req_b0`, in, DATA_LEN: port-0 operands.
- `req_op0`, in, 3: port-0 ALU op.
- `req_a1` / `req_b1` / `req_op1`: same fields for port 1.
- `rsp_valid`, out, 2: result valid for port i.
- `rsp_ready`, in, 2: port i consumes its result.
- `rsp_res`, out, DATA_LEN: registered result, shared by both ports.
- `rsp_overflow`, out, 1: registered `alu` overflow.
- `busy`, out, 1: result register occupied.

## Operation

- Op encoding (one-hot decode inside `alu`): 7 add, 6 sub, 5 not (~a), 4 and, 3 or, 2 xor, 1 less (signed a<b, result 0/1), 0 equ (a==b, result 0/1).
- FSM with two states:
  - EMPTY: result register free.
  - FULL: holds the result for owner port `own`.
- Grant:
  - Round-robin pointer `prio` names the favoured port.
  - When both ports are valid, grant `prio`; otherwise grant the single valid port.
  - On every accepted request, `prio` moves to the other port.
- Slot is free when the state is EMPTY, or when it is FULL and `rsp_ready[own]` is high (drain and refill in the same cycle).
- `req_ready[i]` = slot free & grant==i. Combinational, and it never depends on `req_valid[i]` itself beyond the grant.
- Muxed operands of the granted port drive `alu.a`, `alu.b`, `alu.op`. When nothing is granted, the mux holds port `prio`'s fields; these are don't-care.
- On accept:
  - `rsp_res` and `rsp_overflow` load from the `alu` outputs.
  - `own` is set to the granted port.
  - State becomes FULL.
- On drain without a new accept: state becomes EMPTY. `rsp_res` holds its last value.
- `rsp_valid[i]` = FULL & own==i. Exactly one bit or no bits are ever set.
- `overflow` is passed through for every op. It is meaningful only for add, sub and less.

## Timing

- Reset (async assert, sync-safe deassert):
  - state EMPTY, `prio`=0, `own`=0.
  - `rsp_res`=0, `rsp_overflow`=0.
  - `rsp_valid`=0, `busy`=0.
  - `req_ready` follows from EMPTY: it is 1 for the grant winner.
- Latency: request accepted at edge t, so `rsp_valid` is high after edge t (one cycle).
- Throughput: one op per cycle per block when the owner holds `rsp_ready` high.
- Back-pressure: while FULL and `rsp_ready[own]` is low, both `req_ready` bits are 0 and the result is stable.
- A requester may hold `req_valid` with changing operands only until it is accepted. The block samples the operands only in the accept cycle.
- Reset mid-operation: a pending result is discarded, with no response.
- Both ports valid every cycle with the owner always ready: grants alternate 0,1,0,1… starting with port 0 after reset.

## Structure

- Shared package `alu_pkg` holds:
  - `ALU_OP_*` localparams for the 3-bit codes above.
  - The FSM state constants.
- Sub-module `rr_arb2`: 2-way round-robin grant with an `advance` input and registered `prio`. It is instantiated once.
- `alu` is instantiated once, unchanged.
- The top holds the FSM, the operand mux and the result register.

## Test plan

1. Port 0 only, op=7, a=5, b=3, `rsp_ready`=1 → `rsp_valid`=2'b01 one cycle later, `rsp_res`=8, `rsp_overflow`=0.
2. Both ports valid after reset:
   - port 0: op=6, a=3, b=5. Port 1: op=0, a=9, b=9.
   - Port 0 is served first → `rsp_res`=32'hFFFFFFFE.
   - Next cycle port 1 → `rsp_res`=1, `rsp_valid`=2'b10.
3. op=7, a=32'h7FFFFFFF, b=1 → `rsp_res`=32'h80000000, `rsp_overflow`=1. Then op=1, a=32'hFFFFFFFF (−1), b=1 → `rsp_res`=1.
4. Back-pressure:
   - Port 1 result with `rsp_ready[1]`=0 for 3 cycles while port 0 is valid → `req_ready`=0, and `rsp_res` and `rsp_valid` are stable for all 3 cycles.
   - Raise `rsp_ready[1]` → port 0 is accepted in the same cycle, and its result appears the next cycle.
5. Assert `rst_n`=0 asynchronously while FULL → `rsp_valid`=0 and `rsp_res`=0 immediately, with no clock edge needed. After release, port 0 has priority.
6. Both ports continuously valid with op=4/3/2/5 and random operands, `rsp_ready`=2'b11 → strict 0/1 alternation, one result per cycle, each matching the reference model and its owner.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes and the result-slot FSM states used by the ALU sharing arbiter.
package alu_pkg;

  localparam logic [2:0] ALU_OP_ADD  = 3'd7;
  localparam logic [2:0] ALU_OP_SUB  = 3'd6;
  localparam logic [2:0] ALU_OP_NOT  = 3'd5;
  localparam logic [2:0] ALU_OP_AND  = 3'd4;
  localparam logic [2:0] ALU_OP_OR   = 3'd3;
  localparam logic [2:0] ALU_OP_XOR  = 3'd2;
  localparam logic [2:0] ALU_OP_LESS = 3'd1;
  localparam logic [2:0] ALU_OP_EQU  = 3'd0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  function automatic logic [7:0] op_onehot(input logic [2:0] op);
    return 8'b0000_0001 << op;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU with one-hot op decode; overflow reflects signed add/sub
// (less reports the overflow of its internal a-b).
module alu
  import alu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  input  logic [2:0]          op,
  output logic [DATA_LEN-1:0] res,
  output logic                overflow
);

  localparam int MSB = DATA_LEN - 1;

  logic [7:0]          sel_s;
  logic [DATA_LEN-1:0] sum_s;
  logic [DATA_LEN-1:0] diff_s;
  logic                add_ovf_s;
  logic                sub_ovf_s;

  always_comb begin
    sel_s     = op_onehot(op);
    sum_s     = a + b;
    diff_s    = a - b;
    add_ovf_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
    sub_ovf_s = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
    res       = '0;
    overflow  = 1'b0;
    case (1'b1)
      sel_s[ALU_OP_ADD]: begin
        res      = sum_s;
        overflow = add_ovf_s;
      end
      sel_s[ALU_OP_SUB]: begin
        res      = diff_s;
        overflow = sub_ovf_s;
      end
      sel_s[ALU_OP_NOT]:  res = ~a;
      sel_s[ALU_OP_AND]:  res = a & b;
      sel_s[ALU_OP_OR]:   res = a | b;
      sel_s[ALU_OP_XOR]:  res = a ^ b;
      // Signed compare: sign of a-b corrected by its overflow.
      sel_s[ALU_OP_LESS]: begin
        res      = {{(DATA_LEN-1){1'b0}}, diff_s[MSB] ^ sub_ovf_s};
        overflow = sub_ovf_s;
      end
      sel_s[ALU_OP_EQU]:  res = {{(DATA_LEN-1){1'b0}}, (a == b)};
      default: begin
        res      = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the favoured port toggles on every advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_valid = |valid;
    if (valid == 2'b11) begin
      gnt_idx = prio_q;
    end else if (valid[1]) begin
      gnt_idx = 1'b1;
    end else if (valid[0]) begin
      gnt_idx = 1'b0;
    end else begin
      gnt_idx = prio_q;
    end
    if (advance) begin
      prio_d = ~prio_q;
    end else begin
      prio_d = prio_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU between two requesters: round-robin accept, one-entry
// registered result slot returned to the port that issued the request.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [DATA_LEN-1:0] req_a0,
  input  logic [DATA_LEN-1:0] req_b0,
  input  logic [2:0]          req_op0,
  input  logic [DATA_LEN-1:0] req_a1,
  input  logic [DATA_LEN-1:0] req_b1,
  input  logic [2:0]          req_op1,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_LEN-1:0] rsp_res,
  output logic                rsp_overflow,
  output logic                busy
);

  arb_state_e          state_q, state_d;
  logic                own_q, own_d;
  logic [DATA_LEN-1:0] res_q, res_d;
  logic                ovf_q, ovf_d;

  logic                gnt_valid_s;
  logic                gnt_idx_s;
  logic                drain_s;
  logic                slot_free_s;
  logic                accept_s;
  logic [DATA_LEN-1:0] alu_a_s;
  logic [DATA_LEN-1:0] alu_b_s;
  logic [2:0]          alu_op_s;
  logic [DATA_LEN-1:0] alu_res_s;
  logic                alu_ovf_s;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .advance   (accept_s),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  alu #(.DATA_LEN(DATA_LEN)) u_alu (
    .a        (alu_a_s),
    .b        (alu_b_s),
    .op       (alu_op_s),
    .res      (alu_res_s),
    .overflow (alu_ovf_s)
  );

  // Slot handshake and operand mux; the grant index already falls back to prio when idle.
  always_comb begin
    drain_s     = (state_q == ST_FULL) && rsp_ready[own_q];
    slot_free_s = (state_q == ST_EMPTY) || drain_s;
    req_ready   = 2'b00;
    if (slot_free_s && gnt_valid_s) begin
      req_ready[gnt_idx_s] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
    accept_s = |(req_valid & req_ready);
    if (gnt_idx_s) begin
      alu_a_s  = req_a1;
      alu_b_s  = req_b1;
      alu_op_s = req_op1;
    end else begin
      alu_a_s  = req_a0;
      alu_b_s  = req_b0;
      alu_op_s = req_op0;
    end
  end

  // Next-state: accept (possibly while draining) wins over a plain drain.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (accept_s) begin
      state_d = ST_FULL;
      own_d   = gnt_idx_s;
      res_d   = alu_res_s;
      ovf_d   = alu_ovf_s;
    end else if (drain_s) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      own_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid    = {(state_q == ST_FULL) && own_q, (state_q == ST_FULL) && !own_q};
  assign busy         = (state_q == ST_FULL);
  assign rsp_res      = res_q;
  assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vector table, async-reset sequence and a
// random alternation run, all checked against a queue-based reference model.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = 32'd0, req_b0 = 32'd0, req_a1 = 32'd0, req_b1 = 32'd0;
  logic [2:0]  req_op0 = 3'd0, req_op1 = 3'd0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_res;
  logic        rsp_overflow;
  logic        busy;

  alu_share_arb #(.DATA_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_overflow(rsp_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0, b0;
    logic [2:0]  op0;
    logic [31:0] a1, b1;
    logic [2:0]  op1;
    logic [1:0]  rdy;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic [31:0] exp_res;
    logic        exp_ovf;
    logic        chk_ovf;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        ovf;
    logic        chk_ovf;
  } sb_t;

  sb_t         sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prio_m = 1'b0, full_m = 1'b0, own_m = 1'b0;
  logic [31:0] last_res_m = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o, output logic co);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; o = 1'b0; co = 1'b0;
    case (op)
      3'd7: begin s = sa + sb; r = s[31:0]; co = 1'b1;
                  o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd6: begin s = sa - sb; r = s[31:0]; co = 1'b1;
                  o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd5: r = ~a;
      3'd4: r = a & b;
      3'd3: r = a | b;
      3'd2: r = a ^ b;
      3'd1: begin s = sa - sb; r = (sa < sb) ? 32'd1 : 32'd0; co = 1'b1;
                  o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      default: r = (a == b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [2:0] op0, input logic [31:0] a1, input logic [31:0] b1,
                              input logic [2:0] op1, input logic [1:0] rdy, input logic [1:0] exp_ready,
                              input logic [1:0] exp_rv, input logic [31:0] exp_res,
                              input logic exp_ovf, input logic chk_ovf);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.b0 = b0; v.op0 = op0; v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.rdy = rdy; v.exp_ready = exp_ready; v.exp_rv = exp_rv; v.exp_res = exp_res;
    v.exp_ovf = exp_ovf; v.chk_ovf = chk_ovf;
    return v;
  endfunction

  // Drive one cycle at the falling edge, check outputs, then advance the model to the next rising edge.
  task automatic step(input vec_t v);
    logic [1:0]  exp_rdy;
    logic        gnt;
    sb_t         e;
    logic [31:0] r;
    logic        o, co;
    @(negedge clk);
    req_valid = v.valid;
    req_a0 = v.a0; req_b0 = v.b0; req_op0 = v.op0;
    req_a1 = v.a1; req_b1 = v.b1; req_op1 = v.op1;
    rsp_ready = v.rdy;
    #1;
    if (full_m) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard_empty: model FULL with no queued result at %0t", $time);
      end else begin
        e = sb_q[0];
        chk("rsp_valid", {62'd0, rsp_valid}, e.port ? 64'd2 : 64'd1);
        chk("rsp_res", {32'd0, rsp_res}, {32'd0, e.res});
        if (e.chk_ovf) chk("rsp_overflow", {63'd0, rsp_overflow}, {63'd0, e.ovf});
        if (v.rdy[own_m]) void'(sb_q.pop_front());
      end
    end else begin
      chk("rsp_valid_idle", {62'd0, rsp_valid}, 64'd0);
      chk("rsp_res_hold", {32'd0, rsp_res}, {32'd0, last_res_m});
    end
    chk("busy", {63'd0, busy}, {63'd0, full_m});
    if (v.valid == 2'b11) gnt = prio_m;
    else if (v.valid[1])  gnt = 1'b1;
    else                  gnt = 1'b0;
    exp_rdy = 2'b00;
    if ((!full_m || v.rdy[own_m]) && (v.valid != 2'b00)) exp_rdy[gnt] = 1'b1;
    chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
    if ((v.valid & exp_rdy) != 2'b00) begin
      if (gnt) ref_alu(v.op1, v.a1, v.b1, r, o, co);
      else     ref_alu(v.op0, v.a0, v.b0, r, o, co);
      e.port = gnt; e.res = r; e.ovf = o; e.chk_ovf = co;
      sb_q.push_back(e);
      prio_m = ~prio_m;
      full_m = 1'b1;
      own_m = gnt;
      last_res_m = r;
    end else if (full_m && v.rdy[own_m]) begin
      full_m = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[12];
    vec_t       rv;
    logic [2:0] lop[4];
    lop[0] = ALU_OP_AND; lop[1] = ALU_OP_OR; lop[2] = ALU_OP_XOR; lop[3] = ALU_OP_NOT;

    tbl[0]  = mk(2'b11, 32'd3, 32'd5, ALU_OP_SUB, 32'd9, 32'd9, ALU_OP_EQU, 2'b11, 2'b01, 2'b00, 32'd0, 1'b0, 1'b1);
    tbl[1]  = mk(2'b10, 32'd3, 32'd5, ALU_OP_SUB, 32'd9, 32'd9, ALU_OP_EQU, 2'b11, 2'b10, 2'b01, 32'hFFFFFFFE, 1'b0, 1'b1);
    tbl[2]  = mk(2'b01, 32'd5, 32'd3, ALU_OP_ADD, 32'd0, 32'd0, ALU_OP_EQU, 2'b11, 2'b01, 2'b10, 32'd1, 1'b0, 1'b0);
    tbl[3]  = mk(2'b01, 32'h7FFFFFFF, 32'd1, ALU_OP_ADD, 32'd0, 32'd0, ALU_OP_EQU, 2'b11, 2'b01, 2'b01, 32'd8, 1'b0, 1'b1);
    tbl[4]  = mk(2'b10, 32'd0, 32'd0, ALU_OP_ADD, 32'hFFFFFFFF, 32'd1, ALU_OP_LESS, 2'b11, 2'b10, 2'b01, 32'h80000000, 1'b1, 1'b1);
    tbl[5]  = mk(2'b00, 32'd0, 32'd0, ALU_OP_ADD, 32'd0, 32'd0, ALU_OP_EQU, 2'b11, 2'b00, 2'b10, 32'd1, 1'b0, 1'b1);
    tbl[6]  = mk(2'b10, 32'd0, 32'd0, ALU_OP_ADD, 32'hF0, 32'h0F, ALU_OP_OR, 2'b11, 2'b10, 2'b00, 32'd1, 1'b0, 1'b0);
    tbl[7]  = mk(2'b01, 32'hAA, 32'hFF, ALU_OP_XOR, 32'd0, 32'd0, ALU_OP_EQU, 2'b01, 2'b00, 2'b10, 32'hFF, 1'b0, 1'b0);
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = mk(2'b01, 32'hAA, 32'hFF, ALU_OP_XOR, 32'd0, 32'd0, ALU_OP_EQU, 2'b11, 2'b01, 2'b10, 32'hFF, 1'b0, 1'b0);
    tbl[11] = mk(2'b00, 32'd0, 32'd0, ALU_OP_ADD, 32'd0, 32'd0, ALU_OP_EQU, 2'b11, 2'b00, 2'b01, 32'h55, 1'b0, 1'b0);

    // Reset state, including the combinational ready of an empty slot.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_res", {32'd0, rsp_res}, 64'd0);
    chk("rst_overflow", {63'd0, rsp_overflow}, 64'd0);
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", {62'd0, req_ready}, 64'd1);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i]);
      chk($sformatf("tbl%0d_ready", i), {62'd0, req_ready}, {62'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_rsp_valid", i), {62'd0, rsp_valid}, {62'd0, tbl[i].exp_rv});
      chk($sformatf("tbl%0d_rsp_res", i), {32'd0, rsp_res}, {32'd0, tbl[i].exp_res});
      if (tbl[i].chk_ovf) chk($sformatf("tbl%0d_ovf", i), {63'd0, rsp_overflow}, {63'd0, tbl[i].exp_ovf});
    end

    // Async reset while FULL: outputs clear without a clock edge.
    step(mk(2'b01, 32'd1, 32'd1, ALU_OP_ADD, 32'd0, 32'd0, ALU_OP_EQU, 2'b00, 2'b01, 2'b00, 32'd0, 1'b0, 1'b0));
    @(negedge clk);
    #2;
    chk("pre_rst_full", {62'd0, rsp_valid}, 64'd1);
    chk("pre_rst_res", {32'd0, rsp_res}, 64'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {62'd0, rsp_valid}, 64'd0);
    chk("async_rst_res", {32'd0, rsp_res}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    sb_q.delete();
    prio_m = 1'b0; full_m = 1'b0; own_m = 1'b0; last_res_m = 32'd0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(2'b11, 32'd12, 32'd10, ALU_OP_AND, 32'd6, 32'd3, ALU_OP_OR, 2'b11, 2'b00, 2'b00, 32'd0, 1'b0, 1'b0));
    chk("post_rst_prio", {62'd0, req_ready}, 64'd1);

    // Both ports always valid, owner always ready: strict alternation from port 1 onward.
    for (int i = 0; i < 200; i++) begin
      rv = mk(2'b11, $urandom, $urandom, lop[$urandom_range(0, 3)],
              $urandom, $urandom, lop[$urandom_range(0, 3)], 2'b11, 2'b00, 2'b00, 32'd0, 1'b0, 1'b0);
      step(rv);
      chk("alternate", {62'd0, req_ready}, (i % 2 == 0) ? 64'd2 : 64'd1);
    end
    step(mk(2'b00, 32'd0, 32'd0, ALU_OP_ADD, 32'd0, 32'd0, ALU_OP_EQU, 2'b11, 2'b00, 2'b00, 32'd0, 1'b0, 1'b0));
    step(mk(2'b00, 32'd0, 32'd0, ALU_OP_ADD, 32'd0, 32'd0, ALU_OP_EQU, 2'b11, 2'b00, 2'b00, 32'd0, 1'b0, 1'b0));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
